// File: rtl/led_pattern_sched.sv
// Round-robin scheduler that shares one LED bank between NREQ pattern requesters.
// Define LED_SCHED_FIXED_PRIO_EN for fixed-priority arbitration (lowest index wins).
module led_pattern_sched #(
    parameter int              LED_W        = 12,
    parameter int              NREQ         = 4,
    parameter logic [23:0]     TICK_DIV     = 24'd8388608,
    parameter int              HOLD_STEPS   = 12,
    parameter logic [LED_W-1:0] IDLE_PATTERN = 12'b000111111111
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LED_W-1:0] pat_data,
    input  logic [NREQ-1:0]       dir,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [3:0]            step,
    output logic                  done,
    output logic [LED_W-1:0]      led
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_RELEASE
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   winner_q, winner_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [23:0]        presc_q, presc_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic [3:0]         step_q, step_d;
    logic               done_q, done_d;

    logic               arb_found;
    logic [PTR_W-1:0]   arb_win;
    logic               tick;
    logic [LED_W-1:0]   pat_sel;
    logic [LED_W-1:0]   led_rot;

`ifdef LED_SCHED_FIXED_PRIO_EN
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!arb_found && req[PTR_W'(i)]) begin
                arb_found = 1'b1;
                arb_win   = PTR_W'(i);
            end
        end
    end
`else
    // Scan starts one past the last winner so every requester gets a turn.
    always_comb begin
        int unsigned scan_idx;
        arb_found = 1'b0;
        arb_win   = '0;
        scan_idx  = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            scan_idx = 32'(rr_ptr_q) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!arb_found && req[PTR_W'(scan_idx)]) begin
                arb_found = 1'b1;
                arb_win   = PTR_W'(scan_idx);
            end
        end
    end
`endif

    always_comb begin
        pat_sel = pat_data[LED_W-1:0];
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (winner_q == PTR_W'(i)) begin
                pat_sel = pat_data[i*LED_W +: LED_W];
            end
        end
    end

    assign tick    = (presc_q == (TICK_DIV - 24'd1));
    assign led_rot = dir[winner_q] ? {led_q[0], led_q[LED_W-1:1]}
                                   : {led_q[LED_W-2:0], led_q[LED_W-1]};

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        rr_ptr_d = rr_ptr_q;
        presc_d  = presc_q;
        led_d    = led_q;
        gnt_d    = gnt_q;
        busy_d   = busy_q;
        step_d   = step_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                led_d  = IDLE_PATTERN;
                gnt_d  = '0;
                busy_d = 1'b0;
                if (arb_found) begin
                    winner_d = arb_win;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                gnt_d   = NREQ'(1) << winner_q;
                busy_d  = 1'b1;
                led_d   = pat_sel;
                step_d  = '0;
                presc_d = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                // An abort suppresses any rotation due on the same cycle.
                if (!req[winner_q]) begin
                    state_d = S_RELEASE;
                end else begin
                    presc_d = tick ? '0 : presc_q + 24'd1;
                    if (tick) begin
                        led_d  = led_rot;
                        step_d = step_q + 4'd1;
                        if (step_q == 4'(HOLD_STEPS - 1)) begin
                            state_d = S_RELEASE;
                        end
                    end
                end
            end
            S_RELEASE: begin
                gnt_d    = '0;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                rr_ptr_d = winner_q;
                led_d    = IDLE_PATTERN;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            winner_q <= '0;
            rr_ptr_q <= PTR_W'(NREQ - 1);
            presc_q  <= '0;
            led_q    <= IDLE_PATTERN;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            step_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            rr_ptr_q <= rr_ptr_d;
            presc_q  <= presc_d;
            led_q    <= led_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
            step_q   <= step_d;
            done_q   <= done_d;
        end
    end

    assign gnt  = gnt_q;
    assign busy = busy_q;
    assign step = step_q;
    assign done = done_q;
    assign led  = led_q;

endmodule

// File: tb/tb_led_pattern_sched.sv
// Directed bench for led_pattern_sched: vector table plus hand-written
// round-robin, mid-run reset and abort-on-tick sequences.
module tb_led_pattern_sched;

    localparam logic [11:0] IDLE = 12'b000111111111;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [47:0] pat_data;
    logic [3:0]  dir;
    logic [3:0]  gnt;
    logic        busy;
    logic [3:0]  step;
    logic        done;
    logic [11:0] led;

    int pass_cnt  = 0;
    int total_cnt = 0;

    led_pattern_sched #(
        .LED_W       (12),
        .NREQ        (4),
        .TICK_DIV    (24'd4),
        .HOLD_STEPS  (12),
        .IDLE_PATTERN(12'b000111111111)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .pat_data(pat_data),
        .dir     (dir),
        .gnt     (gnt),
        .busy    (busy),
        .step    (step),
        .done    (done),
        .led     (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  dir;
        int          ncyc;
        logic [3:0]  gnt;
        logic        busy;
        logic [3:0]  step;
        logic        done;
        logic [11:0] led;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == 4'b0000 && n < 100);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == 1'b0 && n < 200);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] rr_exp [5];
        int n;

`ifdef LED_SCHED_FIXED_PRIO_EN
        rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif

        //                req      dir      n   gnt      bsy   step   done  led
        tbl[0]  = '{4'b0001, 4'b0000,  1, 4'b0000, 1'b0, 4'd0,  1'b0, IDLE};
        tbl[1]  = '{4'b0001, 4'b0000,  1, 4'b0001, 1'b1, 4'd0,  1'b0, 12'b000011101101};
        tbl[2]  = '{4'b0001, 4'b0000,  3, 4'b0001, 1'b1, 4'd0,  1'b0, 12'b000011101101};
        tbl[3]  = '{4'b0001, 4'b0000,  1, 4'b0001, 1'b1, 4'd1,  1'b0, 12'b000111011010};
        tbl[4]  = '{4'b0001, 4'b0000,  4, 4'b0001, 1'b1, 4'd2,  1'b0, 12'b001110110100};
        tbl[5]  = '{4'b0001, 4'b0000, 40, 4'b0001, 1'b1, 4'd12, 1'b0, 12'b000011101101};
        tbl[6]  = '{4'b0001, 4'b0000,  1, 4'b0000, 1'b0, 4'd12, 1'b1, IDLE};
        tbl[7]  = '{4'b0000, 4'b0000,  1, 4'b0000, 1'b0, 4'd12, 1'b0, IDLE};
        tbl[8]  = '{4'b0010, 4'b0010,  2, 4'b0010, 1'b1, 4'd0,  1'b0, 12'b000000000001};
        tbl[9]  = '{4'b0010, 4'b0010,  4, 4'b0010, 1'b1, 4'd1,  1'b0, 12'b100000000000};
        tbl[10] = '{4'b0010, 4'b0010,  4, 4'b0010, 1'b1, 4'd2,  1'b0, 12'b010000000000};
        tbl[11] = '{4'b0000, 4'b0010,  1, 4'b0010, 1'b1, 4'd2,  1'b0, 12'b010000000000};
        tbl[12] = '{4'b0000, 4'b0010,  1, 4'b0000, 1'b0, 4'd2,  1'b1, IDLE};
        tbl[13] = '{4'b0000, 4'b0010,  1, 4'b0000, 1'b0, 4'd2,  1'b0, IDLE};

        pat_data = {12'b101010101010, 12'b110000000011, 12'b000000000001, 12'b000011101101};
        rst_n = 1'b0;
        req   = 4'b0000;
        dir   = 4'b0000;
        repeat (3) @(negedge clk);
        check("reset_led",  32'(led),  32'(IDLE));
        check("reset_gnt",  32'(gnt),  32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_step", 32'(step), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            req = tbl[i].req;
            dir = tbl[i].dir;
            repeat (tbl[i].ncyc) @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_gnt", i),  32'(gnt),  32'(tbl[i].gnt));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            check($sformatf("v%0d_step", i), 32'(step), 32'(tbl[i].step));
            check($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].done));
            check($sformatf("v%0d_led", i),  32'(led),  32'(tbl[i].led));
        end

        // Arbitration order from a fresh reset with all requesters active.
        rst_n = 1'b0;
        dir   = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_gnt(n);
            check($sformatf("rr%0d_gnt", g), 32'(gnt), 32'(rr_exp[g]));
            check($sformatf("rr%0d_latency", g), 32'(n), (g == 0) ? 32'd2 : 32'd1);
            if (g < 4) begin
                wait_done(n);
                check($sformatf("rr%0d_done", g), 32'(done), 32'h1);
                check($sformatf("rr%0d_gnt_at_done", g), 32'(gnt), 32'h0);
                @(negedge clk);
                check($sformatf("rr%0d_done_width", g), 32'(done), 32'h0);
                check($sformatf("rr%0d_idle_gap", g), 32'(gnt), 32'h0);
            end
        end

        // Asynchronous reset in the middle of RUN.
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_led",  32'(led),  32'(IDLE));
        check("midrst_gnt",  32'(gnt),  32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_step", 32'(step), 32'h0);
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Abort sampled on the same cycle the 4th tick would fire.
        req = 4'b0001;
        dir = 4'b0000;
        wait_gnt(n);
        check("abort_gnt", 32'(gnt), 32'h1);
        repeat (15) @(posedge clk);
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        check("abort_step", 32'(step), 32'd3);
        check("abort_led",  32'(led),  32'(12'b011101101000));
        check("abort_busy", 32'(busy), 32'h1);
        check("abort_done_early", 32'(done), 32'h0);
        @(negedge clk);
        check("abort_done", 32'(done), 32'h1);
        check("abort_step_hold", 32'(step), 32'd3);
        check("abort_led_idle", 32'(led), 32'(IDLE));
        check("abort_gnt_drop", 32'(gnt), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
